// File: rtl/fc_result_writer_bram.sv
// Write-back end of the FC datapath: takes NUM_CORE-wide result beats and
// serializes them into one BRAM word per cycle at consecutive addresses.
module fc_result_writer_bram #(
    parameter int CNT_BIT  = 31,
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 12,
    parameter int NUM_CORE = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_run,
    input  logic [CNT_BIT-1:0]           i_num_cnt,
    input  logic [AWIDTH-1:0]            i_base_addr,
    input  logic                         i_valid,
    input  logic [NUM_CORE*DWIDTH-1:0]   i_result,
    output logic                         o_ready,
    output logic                         o_idle,
    output logic                         o_write,
    output logic                         o_done,
    output logic                         o_overflow,
    output logic [AWIDTH-1:0]            addr_b,
    output logic                         ce_b,
    output logic                         we_b,
    output logic [DWIDTH-1:0]            d_b,
    input  logic [DWIDTH-1:0]            q_b
);
    localparam int LW  = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
    localparam int WCW = CNT_BIT + LW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                       state;
    logic [CNT_BIT-1:0]           num_cnt;
    logic [CNT_BIT-1:0]           beat_cnt;
    logic [AWIDTH-1:0]            base_addr;
    logic [WCW-1:0]               word_cnt;
    logic [LW-1:0]                lane;
    logic                         busy;
    logic [NUM_CORE*DWIDTH-1:0]   shadow;
    logic [NUM_CORE-1:0][DWIDTH-1:0] lanes;
    logic [WCW-1:0]               total_words;
    logic [WCW-1:0]               word_next;
    logic                         last_lane;
    logic                         beats_left;
    logic                         accept;
    logic                         last_write;
    logic                         unused_ok;

    // Lane 0 lives in the most significant slice of the beat.
    for (genvar k = 0; k < NUM_CORE; k++) begin : g_lane
        assign lanes[k] = shadow[(NUM_CORE-k)*DWIDTH-1 -: DWIDTH];
    end

    assign total_words = WCW'(num_cnt) * WCW'(NUM_CORE);
    assign last_lane   = (lane == LW'(NUM_CORE-1));
    assign beats_left  = (beat_cnt < num_cnt);
    assign accept      = (state == S_RUN) && beats_left && (!busy || last_lane);
    assign last_write  = busy && (word_cnt == total_words - WCW'(1));
    // Address of the word presented after this edge when a new beat is loaded.
    assign word_next   = busy ? word_cnt + WCW'(1) : word_cnt;

    assign o_ready   = accept;
    assign o_idle    = (state == S_IDLE);
    assign o_write   = (state == S_RUN);
    assign o_done    = (state == S_DONE);
    assign ce_b      = busy;
    assign we_b      = busy;
    assign d_b       = lanes[lane];
    assign unused_ok = ^q_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            num_cnt    <= '0;
            beat_cnt   <= '0;
            base_addr  <= '0;
            word_cnt   <= '0;
            lane       <= '0;
            busy       <= 1'b0;
            shadow     <= '0;
            o_overflow <= 1'b0;
            addr_b     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_run) begin
                        num_cnt    <= i_num_cnt;
                        base_addr  <= i_base_addr;
                        o_overflow <= 1'b0;
                        beat_cnt   <= '0;
                        word_cnt   <= '0;
                        busy       <= 1'b0;
                        state      <= (i_num_cnt == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (busy) begin
                        word_cnt <= word_cnt + WCW'(1);
                        if (!last_lane) begin
                            lane   <= lane + LW'(1);
                            addr_b <= addr_b + AWIDTH'(1);
                        end else if (!accept) begin
                            busy <= 1'b0;
                        end
                    end
                    if (accept) begin
                        shadow   <= i_result;
                        busy     <= 1'b1;
                        lane     <= '0;
                        beat_cnt <= beat_cnt + CNT_BIT'(1);
                        addr_b   <= base_addr + AWIDTH'(word_next);
                    end
                    if (i_valid && !accept && beats_left)
                        o_overflow <= 1'b1;
                    if (last_write) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/fc_result_writer_bram.md
Name: fc_result_writer_bram

Overview:
Write-back end of the fully-connected datapath. Accepts one beat of NUM_CORE parallel core results per handshake, serializes the beat into one BRAM word per cycle, and writes the words to consecutive addresses starting at a programmable base. Uses the same IDLE/RUN/DONE control style as the read-side data mover. Reports idle, write-active, done and a sticky overflow flag.

Parameters:
CNT_BIT, 31, width of beat count
DWIDTH, 32, BRAM word and per-core result width
AWIDTH, 12, BRAM address width
NUM_CORE, 8, results per beat (>=2)

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
i_run  in  1  start pulse; sampled only in S_IDLE
i_num_cnt  in  CNT_BIT  number of beats to write
i_base_addr  in  AWIDTH  first BRAM address
i_valid  in  1  result beat valid
i_result  in  NUM_CORE*DWIDTH  lane k = bits [(NUM_CORE-k)*DWIDTH-1 -: DWIDTH]; lane 0 is the MSB slice
o_ready  out  1  beat accepted when i_valid && o_ready
o_idle  out  1  state == S_IDLE
o_write  out  1  state == S_RUN
o_done  out  1  one-cycle pulse, state == S_DONE
o_overflow  out  1  sticky; a valid beat was dropped
addr_b  out  AWIDTH  BRAM address
ce_b  out  1  BRAM enable
we_b  out  1  BRAM write enable
d_b  out  DWIDTH  BRAM write data
q_b  in  DWIDTH  unused

Behaviour:
- Reset: state S_IDLE, all counters 0, shadow register 0, o_overflow 0, ce_b/we_b 0, addr_b 0, d_b 0, o_ready 0.
- S_IDLE -> S_RUN on i_run. On that edge, capture num_cnt and base_addr, and clear o_overflow, beat_cnt, word_cnt and busy.
- If i_num_cnt == 0 on i_run: S_IDLE -> S_DONE directly. No writes occur.
- S_RUN -> S_DONE on the edge that writes the last word, i.e. word_cnt == num_cnt*NUM_CORE-1 with a write active.
- S_DONE -> S_IDLE unconditionally after 1 cycle.
- i_run in S_RUN or S_DONE is ignored.
- Accept condition: S_RUN && beat_cnt < num_cnt && (!busy || lane == NUM_CORE-1).
  - o_ready equals the accept condition, combinational.
  - Back-to-back beats serialize with no gap cycles.
- On accept: load i_result into the shadow register, set busy, set lane = 0, increment beat_cnt.
- While busy, each cycle:
  - ce_b = we_b = 1.
  - d_b = shadow lane[lane].
  - addr_b = base_addr + word_cnt, truncated to AWIDTH (wraps mod 2^AWIDTH).
  - Then lane and word_cnt increment.
  - At lane == NUM_CORE-1: clear busy unless a new beat is accepted on the same edge.
- Latency: beat accepted at edge t; words are presented during cycles t..t+NUM_CORE-1 and written at edges t+1..t+NUM_CORE.
- When not busy: ce_b = we_b = 0; d_b and addr_b hold their last value.
- o_done asserts in the cycle after the last write edge.
- Overflow: i_valid && !o_ready while in S_RUN with beat_cnt < num_cnt sets o_overflow. The beat is dropped and the done condition is unaffected.
- Beats beyond num_cnt, and i_valid outside S_RUN, are ignored with no flag.
- Reset asserted mid-run: immediate return to reset values; partially written data is left in the BRAM.

Test Plan:
- NUM_CORE=8, num_cnt=1, base=0x010, lanes 0..7 = 0x11..0x88 -> 8 writes at 0x010..0x017 with data 0x11..0x88 in order; o_done pulses 1 cycle later; o_overflow=0.
- num_cnt=3, a new i_valid every 8 cycles aligned to o_ready -> 24 contiguous writes with no gap cycle, addresses base..base+23, o_done once.
- num_cnt=2, i_valid held high every cycle -> beat 1 accepted, the following 7 cycles are dropped with o_overflow=1, the next accepted beat is written, done after 16 writes; o_overflow clears on the next i_run.
- i_num_cnt=0 with i_run -> S_DONE the next cycle, o_done=1 for 1 cycle, we_b never asserted.
- base=0xFFC, num_cnt=1 -> addresses 0xFFC,0xFFD,0xFFE,0xFFF,0x000..0x003.
- reset_n low during the 4th write of a beat -> ce_b/we_b low immediately, o_idle=1 after release; a subsequent run behaves as a fresh run.
